// File: rtl/nibbler_control.sv
// nibbler_control: central sequencer for the 4-bit NibblER CPU.
// Runs IDLE -> FETCH -> EXEC. FETCH pulses fetch_en. EXEC decodes the latched
// opcode into one-cycle strobes and counts the retired instruction.
// Optional feature macro: NIBBLER_SINGLE_STEP_EN adds a step input and a HOLD
// state after every EXEC; a rising edge on step releases one instruction.
// Strobe handshake: every strobe is a single-cycle, level-valid pulse with no
// ready/acknowledge. Downstream registers act on it at the next rising clk edge.
module nibbler_control #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       instruction,
  input  logic             carry,
  input  logic             zero,
`ifdef NIBBLER_SINGLE_STEP_EN
  input  logic             step,
`endif
  input  logic             halt,
  output logic             phase,
  output logic             fetch_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             a_load,
  output logic             flags_load,
  output logic [1:0]       alu_sel,
  output logic [1:0]       bus_src,
  output logic             mem_we,
  output logic             out_load,
  output logic [CNT_W-1:0] retired
);

`ifdef NIBBLER_SINGLE_STEP_EN
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, HOLD} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;
`endif

  state_t state, state_next;

`ifdef NIBBLER_SINGLE_STEP_EN
  logic step_q;
  logic step_edge;

  // Remember the previous value of step so that only a 0->1 transition counts.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) step_q <= 1'b0;
    else        step_q <= step;
  end

  assign step_edge = step & ~step_q;
`endif

  // State register. Reset aborts any instruction in progress.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Retired-instruction counter. It steps on the edge that leaves EXEC and
  // wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               retired <= '0;
    else if (state == EXEC)   retired <= retired + 1'b1;
  end

  // Next-state logic. halt only matters where an instruction has not started.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  state_next = halt ? IDLE : FETCH;
      FETCH: state_next = EXEC;
`ifdef NIBBLER_SINGLE_STEP_EN
      EXEC:  state_next = halt ? IDLE : HOLD;
      HOLD: begin
        if (halt)           state_next = IDLE;
        else if (step_edge) state_next = FETCH;
        else                state_next = HOLD;
      end
`else
      EXEC:  state_next = halt ? IDLE : FETCH;
`endif
      default: state_next = IDLE;
    endcase
  end

  // Output decode. Outside EXEC only fetch_en can be high (during FETCH).
  always_comb begin
    logic jump;
    phase      = 1'b0;
    fetch_en   = 1'b0;
    pc_inc     = 1'b0;
    pc_load    = 1'b0;
    a_load     = 1'b0;
    flags_load = 1'b0;
    alu_sel    = 2'b00;
    bus_src    = 2'b00;
    mem_we     = 1'b0;
    out_load   = 1'b0;
    jump       = 1'b0;
    if (state == FETCH) begin
      fetch_en = 1'b1;
    end else if (state == EXEC) begin
      phase = 1'b1;
      case (instruction)
        4'h0: jump = carry;
        4'h1: jump = ~carry;
        4'h2: begin flags_load = 1'b1; alu_sel = 2'b11; end
        4'h3: begin flags_load = 1'b1; alu_sel = 2'b11; bus_src = 2'b01; end
        4'h4: a_load = 1'b1;
        4'h5: begin a_load = 1'b1; bus_src = 2'b10; end
        4'h6: begin a_load = 1'b1; bus_src = 2'b01; end
        4'h7: mem_we = 1'b1;
        4'h8: jump = zero;
        4'h9: jump = ~zero;
        4'hA: begin a_load = 1'b1; flags_load = 1'b1; alu_sel = 2'b01; end
        4'hB: begin a_load = 1'b1; flags_load = 1'b1; alu_sel = 2'b01; bus_src = 2'b01; end
        4'hC: jump = 1'b1;
        4'hD: out_load = 1'b1;
        4'hE: begin a_load = 1'b1; flags_load = 1'b1; alu_sel = 2'b10; end
        default: begin a_load = 1'b1; flags_load = 1'b1; alu_sel = 2'b10; bus_src = 2'b01; end
      endcase
      pc_load = jump;
      pc_inc  = ~jump;
    end
  end

endmodule

// File: tb/tb_nibbler_control.sv
// Testbench for nibbler_control, built with CNT_W=4 so that counter wrap is
// reached quickly. The reference model tracks the instruction cycle at the
// level of "fetch / execute / idle / hold" and gets the strobes from per-opcode
// lookup sets.
module tb_nibbler_control;
  localparam int CNT_W = 4;

  // Clock and reset
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] instruction = 4'h0;
  logic carry = 1'b0, zero = 1'b0, halt = 1'b0;
`ifdef NIBBLER_SINGLE_STEP_EN
  logic step = 1'b0;
`endif
  logic phase, fetch_en, pc_inc, pc_load, a_load, flags_load, mem_we, out_load;
  logic [1:0] alu_sel, bus_src;
  logic [CNT_W-1:0] retired;

  nibbler_control #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .carry(carry),
    .zero(zero),
`ifdef NIBBLER_SINGLE_STEP_EN
    .step(step),
`endif
    .halt(halt), .phase(phase), .fetch_en(fetch_en), .pc_inc(pc_inc),
    .pc_load(pc_load), .a_load(a_load), .flags_load(flags_load),
    .alu_sel(alu_sel), .bus_src(bus_src), .mem_we(mem_we),
    .out_load(out_load), .retired(retired)
  );

  // Reference model
  localparam int M_IDLE = 0, M_FETCH = 1, M_EXEC = 2, M_HOLD = 3;
  // Opcode membership sets: bit n set means opcode n asserts that strobe.
  localparam logic [15:0] A_LOAD_SET = 16'hCC70; // 4,5,6,A,B,E,F
  localparam logic [15:0] FLAGS_SET  = 16'hCC0C; // 2,3,A,B,E,F
  localparam logic [15:0] RAM_SRC    = 16'h8848; // 3,6,B,F
  localparam logic [15:0] ADD_SET    = 16'h0C00; // A,B
  localparam logic [15:0] NOR_SET    = 16'hC000; // E,F
  localparam logic [15:0] CMP_SET    = 16'h000C; // 2,3

  int m_mode = M_IDLE;
  int m_retired = 0;
  logic m_step_prev = 1'b0;
  int checks = 0;
  int failures = 0;

  function automatic bit jump_taken(input logic [3:0] op, input logic c, input logic z);
    case (op)
      4'h0: return c;
      4'h1: return !c;
      4'h8: return z;
      4'h9: return !z;
      4'hC: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for the current cycle.
  task automatic compare(input string tag);
    bit ex, j;
    logic [1:0] e_alu, e_src;
    ex = (m_mode == M_EXEC);
    j = ex && jump_taken(instruction, carry, zero);
    e_alu = !ex ? 2'd0 : ADD_SET[instruction] ? 2'd1 : NOR_SET[instruction] ? 2'd2 :
            CMP_SET[instruction] ? 2'd3 : 2'd0;
    e_src = !ex ? 2'd0 : RAM_SRC[instruction] ? 2'd1 : (instruction == 4'h5) ? 2'd2 : 2'd0;
    chk({tag, ".phase"}, 8'(phase), 8'(ex));
    chk({tag, ".fetch_en"}, 8'(fetch_en), 8'(m_mode == M_FETCH));
    chk({tag, ".pc_load"}, 8'(pc_load), 8'(j));
    chk({tag, ".pc_inc"}, 8'(pc_inc), 8'(ex && !j));
    chk({tag, ".a_load"}, 8'(a_load), 8'(ex && A_LOAD_SET[instruction]));
    chk({tag, ".flags_load"}, 8'(flags_load), 8'(ex && FLAGS_SET[instruction]));
    chk({tag, ".alu_sel"}, 8'(alu_sel), 8'(e_alu));
    chk({tag, ".bus_src"}, 8'(bus_src), 8'(e_src));
    chk({tag, ".mem_we"}, 8'(mem_we), 8'(ex && instruction == 4'h7));
    chk({tag, ".out_load"}, 8'(out_load), 8'(ex && instruction == 4'hD));
    chk({tag, ".retired"}, 8'(retired), 8'(m_retired));
  endtask

  // Driver: check mid-cycle, advance the model at the edge, return just after it.
  task automatic cycle(input string tag);
    bit edge_seen;
    @(negedge clk);
    compare(tag);
    @(posedge clk);
`ifdef NIBBLER_SINGLE_STEP_EN
    edge_seen = step && !m_step_prev;
    m_step_prev = step;
`else
    edge_seen = 1'b0;
`endif
    case (m_mode)
      M_IDLE:  m_mode = halt ? M_IDLE : M_FETCH;
      M_FETCH: m_mode = M_EXEC;
      M_EXEC: begin
        m_retired = (m_retired + 1) % (1 << CNT_W);
`ifdef NIBBLER_SINGLE_STEP_EN
        m_mode = halt ? M_IDLE : M_HOLD;
`else
        m_mode = halt ? M_IDLE : M_FETCH;
`endif
      end
      default: m_mode = halt ? M_IDLE : (edge_seen ? M_FETCH : M_HOLD);
    endcase
    #1;
  endtask

  task automatic run_instr(input logic [3:0] op, input logic c, input logic z,
                           input logic h, input string tag);
    instruction = op; halt = 1'b0;
    cycle({tag, ".fetch"});
    carry = c; zero = z; halt = h;
    cycle({tag, ".exec"});
    halt = 1'b0;
  endtask

  // Stimulus sequence
  initial begin
    // Reset held for three cycles: everything quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      compare("reset");
      @(posedge clk);
    end
    #1 reset = 1'b1;
    cycle("idle_after_reset");

    // Directed decode cases.
    run_instr(4'hA, 1'b0, 1'b0, 1'b0, "addi");
    run_instr(4'hF, 1'b0, 1'b0, 1'b0, "norm");
    run_instr(4'h0, 1'b1, 1'b0, 1'b0, "jc_taken");
    run_instr(4'h0, 1'b0, 1'b0, 1'b0, "jc_not_taken");
    run_instr(4'h9, 1'b0, 1'b0, 1'b0, "jnz_taken");
    run_instr(4'hC, 1'b0, 1'b0, 1'b0, "jmp");
    run_instr(4'h5, 1'b1, 1'b1, 1'b0, "in");
`ifdef NIBBLER_SINGLE_STEP_EN
    // Sitting in HOLD without a step: nothing happens.
    for (int i = 0; i < 10; i++) cycle("hold_wait");
    step = 1'b1; cycle("step_rise");
    step = 1'b0;
    for (int i = 0; i < 4; i++) cycle("step_one");
    step = 1'b1;
    for (int i = 0; i < 6; i++) cycle("step_held");
    step = 1'b0; cycle("step_low");
    step = 1'b1; halt = 1'b1; cycle("step_and_halt");
    step = 1'b0;
    cycle("idle_halted");
    halt = 1'b0; cycle("idle_release");
`endif

    // Halt during ST: the store still happens, then the sequencer parks.
    run_instr(4'h7, 1'b0, 1'b0, 1'b1, "st_halt");
    halt = 1'b1;
    for (int i = 0; i < 3; i++) cycle("halted");
    halt = 1'b0;
    cycle("unhalt_idle");

    // Randomized run, long enough for the counter to wrap several times.
    for (int i = 0; i < 300; i++) begin
      instruction = 4'($urandom_range(0, 15));
      carry = 1'($urandom_range(0, 1));
      zero  = 1'($urandom_range(0, 1));
      halt  = ($urandom_range(0, 9) == 0);
`ifdef NIBBLER_SINGLE_STEP_EN
      step  = 1'($urandom_range(0, 1));
`endif
      cycle("random");
    end
    halt = 1'b0;
`ifdef NIBBLER_SINGLE_STEP_EN
    step = 1'b0;
    cycle("drain_step_low");
    step = 1'b1;
    for (int i = 0; i < 3; i++) cycle("drain_step");
    step = 1'b0;
`endif
    // Reach a fetch, then abort the next EXEC with reset.
    for (int i = 0; i < 4 && m_mode != M_FETCH; i++) cycle("seek_fetch");
    instruction = 4'hB;
    if (m_mode == M_FETCH) begin
      cycle("pre_abort_fetch");
      #2 reset = 1'b0;
      #1;
      m_mode = M_IDLE; m_retired = 0; m_step_prev = 1'b0;
      compare("abort");
    end else begin
      chk("seek_fetch_timeout", 8'(m_mode), 8'(M_FETCH));
    end
    @(posedge clk); #1 reset = 1'b1;
    cycle("post_abort_idle");
    cycle("post_abort_fetch");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
